// File: rtl/fetch_queue_stage.sv
// Instruction-fetch front end: issues sequential word fetches (one outstanding at a time)
// and buffers returned {pc, inst} pairs in a small FIFO for the decode stage.
module fetch_queue_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   redirect_pc_al;
  logic [CW-1:0] count;
  logic [CW-1:0] credit;
  logic          credit_ok;
  logic          issue;
  logic [31:0]   issue_addr;
  logic          enq;
  logic          deq;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];

  assign redirect_pc_al = redirect_pc & ~32'd3;

  // An outstanding request already owns a queue slot, so it counts against the space left.
  assign credit    = count + CW'(state_q != IDLE);
  assign credit_ok = credit < DEPTH_C;

  // NOTE: every variable gets a default at the top of always_comb; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    issue      = 1'b0;
    issue_addr = pc_q;
    enq        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_pc_al;
        end else if (credit_ok) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc_al;
          state_d = imem_resp ? IDLE : DISCARD;
        end else if (imem_resp) begin
          enq  = 1'b1;
          pc_d = pc_q + 32'd4;
          if (credit_ok) begin
            issue      = 1'b1;
            issue_addr = pc_q + 32'd4;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect_valid) pc_d = redirect_pc_al;
        if (imem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      issue = 1'b0;
      enq   = 1'b0;
    end
  end

  assign imem_rmask = issue ? 4'hf : 4'h0;
  assign imem_addr  = issue ? issue_addr : 32'd0;

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // A flushed cycle ignores any dequeue; decode drops that instruction on its own.
  assign deq = out_valid & out_ready & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      if (enq && !deq)      count <= count + CW'(1);
      else if (!enq && deq) count <= count - CW'(1);
    end
  end

  // NOTE: the storage array has no reset; count gates every read, so stale contents are
  // never visible and the array can map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[wr_ptr]   <= pc_q;
      q_inst[wr_ptr] <= imem_rdata;
    end
  end

  assign out_valid = count != '0;
  assign out_pc    = out_valid ? q_pc[rd_ptr]   : 32'd0;
  assign out_inst  = out_valid ? q_inst[rd_ptr] : 32'd0;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(enq && count == DEPTH_C));

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: directed scenarios plus randomized traffic,
// checked by a fetch-stream reference model and a scoreboard-driven output monitor.
module tb_fetch_queue_stage;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h1eceb000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  fetch_queue_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          abandoned;
    bit          killed;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          n_req    = 0;
  int          n_pops   = 0;
  bit          started  = 0;
  bit          rst_v, redir_v, ready_v, rand_lat;
  logic [31:0] redir_pc_v;
  int          lat_v;
  mreq_t       pend[$];
  ent_t        sb[$];
  bit          busy;
  bit          push_now;
  bit          req_now;
  logic [31:0] req_addr_now;
  logic [31:0] exp_fetch_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h5a5ac3c3;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // One clock cycle: drive inputs at negedge, play the memory, then update the reference model.
  task automatic step();
    mreq_t m;
    bit    deliver;
    @(negedge clk);
    cyc++;
    rst            = rst_v;
    redirect_valid = redir_v;
    redirect_pc    = redir_pc_v;
    out_ready      = ready_v;
    deliver  = 1'b0;
    push_now = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      m       = pend.pop_front();
      deliver = 1'b1;
    end
    imem_resp  = deliver;
    imem_rdata = deliver ? mem_word(m.addr) : $urandom();
    #1;
    if (deliver && !m.abandoned) begin
      busy = 1'b0;
      if (!m.killed && !redir_v && !rst_v) begin
        sb.push_back('{m.addr, mem_word(m.addr)});
        push_now = 1'b1;
      end
    end
    req_now      = imem_rmask != 4'h0;
    req_addr_now = imem_addr;
    if (req_now) begin
      check("req_rmask", {28'd0, imem_rmask}, 32'hf);
      check("req_addr", imem_addr, exp_fetch_pc);
      check("req_legal", {28'd0, rst_v, redir_v, busy, sb.size() >= DEPTH}, 32'd0);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      busy = 1'b1;
      n_req++;
      pend.push_back('{imem_addr, cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat_v), 1'b0, 1'b0});
    end
    if (rst_v) begin
      exp_fetch_pc = RESET_PC;
      busy = 1'b0;
      foreach (pend[i]) pend[i].abandoned = 1'b1;
    end else if (redir_v) begin
      exp_fetch_pc = redir_pc_v & ~32'd3;
      foreach (pend[i]) pend[i].killed = 1'b1;
    end
  endtask

  // Output monitor: compares the queue head against the scoreboard on each handshake.
  int   vis;
  ent_t mon_e;
  always @(negedge clk) begin
    #2;
    if (started) begin
      vis = sb.size() - (push_now ? 1 : 0);
      check("out_valid", {31'd0, out_valid}, {31'd0, vis > 0});
      if (!out_valid) begin
        check("empty_pc", out_pc, 32'd0);
        check("empty_inst", out_inst, 32'd0);
      end else if (vis > 0 && out_ready && !redirect_valid && !rst) begin
        mon_e = sb.pop_front();
        n_pops++;
        check("deq_pc", out_pc, mon_e.pc);
        check("deq_inst", out_inst, mon_e.inst);
      end
      if (rst || redirect_valid) sb.delete();
    end
  end

  task automatic do_reset();
    rst_v    = 1'b1;
    redir_v  = 1'b0;
    rand_lat = 1'b0;
    step();
    started = 1'b1;
    step();
    check("rst_no_req", {31'd0, req_now}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    rst_v = 1'b0;
    pend.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int req0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0;
    rst_v = 1'b1; redir_v = 1'b0; ready_v = 1'b0; redir_pc_v = '0; lat_v = 1; rand_lat = 1'b0;
    busy = 1'b0; exp_fetch_pc = RESET_PC;

    // Back-to-back fetches with a 1-cycle memory.
    do_reset();
    lat_v = 1; ready_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_req", {31'd0, req_now}, 32'd1);
      check("t1_addr", req_addr_now, RESET_PC + 32'(4 * i));
    end
    check("t1_head_pc", out_pc, RESET_PC);
    check("t1_head_inst", out_inst, mem_word(RESET_PC));
    step();
    check("t1_next_pc", out_pc, RESET_PC + 32'd4);

    // Decode stalled: exactly DEPTH fetches, then one dequeue releases one more.
    do_reset();
    ready_v = 1'b0;
    req0 = n_req;
    repeat (10) step();
    check("t2_fill_reqs", 32'(n_req - req0), 32'(DEPTH));
    check("t2_head_pc", out_pc, RESET_PC);
    ready_v = 1'b1;
    step();
    check("t2_deq_no_req", {31'd0, req_now}, 32'd0);
    ready_v = 1'b0;
    step();
    check("t2_refill_req", {31'd0, req_now}, 32'd1);
    check("t2_refill_addr", req_addr_now, RESET_PC + 32'h10);
    check("t2_head_after", out_pc, RESET_PC + 32'd4);

    // Redirect while a 3-cycle request is outstanding.
    do_reset();
    lat_v = 3; ready_v = 1'b1;
    step();
    redir_v = 1'b1; redir_pc_v = 32'h1eceb100;
    step();
    check("t3_redir_no_req", {31'd0, req_now}, 32'd0);
    redir_v = 1'b0;
    k = 0;
    do begin step(); k++; end while (!req_now && k < 10);
    check("t3_req_delay", 32'(k), 32'd3);
    check("t3_req_addr", req_addr_now, 32'h1eceb100);
    k = 0;
    do begin step(); k++; end while (!out_valid && k < 10);
    check("t3_first_pc", out_pc, 32'h1eceb100);

    // Redirect in the same cycle as the response.
    do_reset();
    lat_v = 2;
    step();
    step();
    redir_v = 1'b1; redir_pc_v = 32'h1eceb102;
    step();
    check("t4_no_req", {31'd0, req_now}, 32'd0);
    redir_v = 1'b0;
    step();
    check("t4_req", {31'd0, req_now}, 32'd1);
    check("t4_addr", req_addr_now, 32'h1eceb100);
    check("t4_empty", {31'd0, out_valid}, 32'd0);

    // Steady enqueue + dequeue at count 2 across pointer wrap.
    do_reset();
    lat_v = 1; ready_v = 1'b0;
    repeat (3) step();
    ready_v = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("t5_req", {31'd0, req_now}, 32'd1);
      check("t5_head_pc", out_pc, RESET_PC + 32'(4 * i));
      check("t5_lag", req_addr_now - out_pc, 32'd12);
    end

    // Reset mid-request; the stale response lands after reset.
    do_reset();
    lat_v = 2; ready_v = 1'b1;
    step();
    rst_v = 1'b1;
    step();
    check("t6_rst_no_req", {31'd0, req_now}, 32'd0);
    rst_v = 1'b0;
    step();
    check("t6_req", {31'd0, req_now}, 32'd1);
    check("t6_addr", req_addr_now, RESET_PC);
    check("t6_empty", {31'd0, out_valid}, 32'd0);
    step();
    check("t6_still_empty", {31'd0, out_valid}, 32'd0);
    step();
    step();
    check("t6_first_pc", out_pc, RESET_PC);
    check("t6_first_inst", out_inst, mem_word(RESET_PC));

    // PC wraps past 32'hfffffffc.
    do_reset();
    lat_v = 1; ready_v = 1'b1;
    redir_v = 1'b1; redir_pc_v = 32'hfffffffa;
    step();
    redir_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t7_addr", req_addr_now, 32'hfffffff8 + 32'(4 * i));
    end
    step();
    step();
    check("t7_wrap_pc", out_pc, 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    rand_lat = 1'b1;
    k = n_pops;
    for (int i = 0; i < 3000; i++) begin
      ready_v    = $urandom_range(0, 3) != 0;
      redir_v    = $urandom_range(0, 39) == 0;
      redir_pc_v = $urandom();
      step();
    end
    redir_v = 1'b0;
    check("rand_progress", {31'd0, (n_pops - k) > 200}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
